// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic elastic pipeline stage register.
//
// Moves a {ctrl, data} entry from one pipeline stage to the next under a
// valid/ready handshake. A main entry (M) drives the outputs. A skid entry
// (S) catches the one extra entry that arrives in the cycle back-pressure is
// first seen, which keeps In_Ready purely registered while still sustaining
// one entry per cycle. Flush turns every held entry into a control bubble
// and leaves the data fields alone.
//
// Ports:
//   CLOCK, RESET_N      rising-edge clock, asynchronous active-low reset
//   In_Valid/In_Ready   upstream handshake (In_Ready = skid entry empty)
//   Ctrl_In, Data_In    upstream control / data bundles
//   Out_Valid/Out_Ready downstream handshake (Out_Valid = main entry valid)
//   Ctrl_Out, Data_Out  main-entry bundles (Ctrl_Out optionally gated)
//   Flush               squash all held entries at this edge
//   Occupancy           number of valid entries held (0..2)
module pipe_stage_reg #(
    parameter int              CTRL_W     = 16,
    parameter int              DATA_W     = 128,
    parameter logic [CTRL_W-1:0] CTRL_RESET = '0,
    parameter bit              GATE_CTRL  = 1'b1
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [CTRL_W-1:0] Ctrl_In,
    input  logic [DATA_W-1:0] Data_In,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [CTRL_W-1:0] Ctrl_Out,
    output logic [DATA_W-1:0] Data_Out,
    input  logic              Flush,
    output logic [1:0]        Occupancy
);

    typedef struct packed {
        logic              vld;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t m_q, s_q;
    entry_t m_d, s_d;
    entry_t in_ent;
    logic   in_xfer;
    logic   out_xfer;

    assign in_ent   = '{vld: 1'b1, ctrl: Ctrl_In, data: Data_In};
    // S empty is exactly the registered ready, so no Out_Ready path reaches In_Ready.
    assign in_xfer  = In_Valid & ~s_q.vld;
    assign out_xfer = m_q.vld & Out_Ready;

    always_comb begin
        m_d = m_q;
        s_d = s_q;
        if (Flush) begin
            // Bubble out everything; data is left as-is to avoid needless toggling.
            m_d.vld  = 1'b0;
            s_d.vld  = 1'b0;
            m_d.ctrl = CTRL_RESET;
            s_d.ctrl = CTRL_RESET;
        end else if (!m_q.vld) begin
            // S is never valid while M is empty.
            if (in_xfer) m_d = in_ent;
        end else if (out_xfer) begin
            if (s_q.vld) begin
                // In_Ready was low, so nothing new can be arriving this edge.
                m_d     = s_q;
                s_d.vld = 1'b0;
            end else if (in_xfer) begin
                m_d = in_ent;
            end else begin
                m_d.vld = 1'b0;
            end
        end else if (in_xfer) begin
            // Stalled with M full: absorb the in-flight entry into the skid slot.
            s_d = in_ent;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_q <= '{vld: 1'b0, ctrl: CTRL_RESET, data: '0};
            s_q <= '{vld: 1'b0, ctrl: CTRL_RESET, data: '0};
        end else begin
            m_q <= m_d;
            s_q <= s_d;
        end
    end

    assign In_Ready  = ~s_q.vld;
    assign Out_Valid = m_q.vld;
    assign Ctrl_Out  = (GATE_CTRL && !m_q.vld) ? CTRL_RESET : m_q.ctrl;
    assign Data_Out  = m_q.data;
    assign Occupancy = {1'b0, m_q.vld} + {1'b0, s_q.vld};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: bench for pipe_stage_reg.
//
// Two instances share all inputs: one with gated control output, one with
// raw control output. A queue-based model of the stage (at most two entries,
// front = what the stage presents) is compared against both instances on
// every falling edge. Directed sequences with literal expectations cover
// reset, streaming, back-pressure, flush and the control gating option, then
// a long randomized run with occasional flush and reset follows.
module tb_pipe_stage_reg;

    localparam int              CW = 16;
    localparam int              DW = 32;
    localparam logic [CW-1:0]   CR = 16'hA5A5;

    logic          CLOCK = 1'b0;
    logic          RESET_N;
    logic          In_Valid = 1'b0, Out_Ready = 1'b0, Flush = 1'b0;
    logic [CW-1:0] Ctrl_In = '0;
    logic [DW-1:0] Data_In = '0;

    logic          In_Ready_g, Out_Valid_g, In_Ready_u, Out_Valid_u;
    logic [CW-1:0] Ctrl_Out_g, Ctrl_Out_u;
    logic [DW-1:0] Data_Out_g, Data_Out_u;
    logic [1:0]    Occupancy_g, Occupancy_u;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CTRL_RESET(CR), .GATE_CTRL(1'b1)) dut_g (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .In_Valid(In_Valid), .In_Ready(In_Ready_g),
        .Ctrl_In(Ctrl_In), .Data_In(Data_In), .Out_Valid(Out_Valid_g), .Out_Ready(Out_Ready),
        .Ctrl_Out(Ctrl_Out_g), .Data_Out(Data_Out_g), .Flush(Flush), .Occupancy(Occupancy_g));

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CTRL_RESET(CR), .GATE_CTRL(1'b0)) dut_u (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .In_Valid(In_Valid), .In_Ready(In_Ready_u),
        .Ctrl_In(Ctrl_In), .Data_In(Data_In), .Out_Valid(Out_Valid_u), .Out_Ready(Out_Ready),
        .Ctrl_Out(Ctrl_Out_u), .Data_Out(Data_Out_u), .Flush(Flush), .Occupancy(Occupancy_u));

    always #5 CLOCK = ~CLOCK;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q[$];          // q[0] is the entry the stage presents
    logic [CW-1:0] shc = CR;      // control last shown by the main slot
    logic [DW-1:0] shd = '0;      // data last shown by the main slot
    bit            mdl_ov, mdl_ir;

    always @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            q.delete();
            shc = CR;
            shd = '0;
        end else begin
            mdl_ov = (q.size() != 0);
            mdl_ir = (q.size() < 2);
            if (Flush) begin
                q.delete();
                shc = CR;
            end else begin
                if (mdl_ov && Out_Ready) void'(q.pop_front());
                if (In_Valid && mdl_ir) q.push_back('{c: Ctrl_In, d: Data_In});
                if (q.size() != 0) begin
                    shc = q[0].c;
                    shd = q[0].d;
                end
            end
        end
    end

    always @(negedge CLOCK) begin
        check("out_valid", 64'(Out_Valid_g), 64'(q.size() != 0));
        check("in_ready",  64'(In_Ready_g),  64'(q.size() < 2));
        check("occupancy", 64'(Occupancy_g), 64'(q.size()));
        check("data_out",  64'(Data_Out_g),  64'(shd));
        check("ctrl_gated", 64'(Ctrl_Out_g), 64'((q.size() != 0) ? shc : CR));
        check("ctrl_raw",  64'(Ctrl_Out_u),  64'(shc));
        check("occ_raw",   64'(Occupancy_u), 64'(q.size()));
        check("data_raw",  64'(Data_Out_u),  64'(shd));
    end

    // ---------------- stimulus ----------------
    logic [DW-1:0] delivered[$];

    // Called at posedge+2; applies inputs for the coming edge, reports whether
    // the input was accepted and records what downstream consumed.
    task cyc(input logic iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
             input logic ordy, input logic fl, output logic acc);
        logic ao;
        logic [DW-1:0] dout;
        In_Valid  = iv;
        Ctrl_In   = c;
        Data_In   = d;
        Out_Ready = ordy;
        Flush     = fl;
        #1;
        acc  = iv & In_Ready_g;
        ao   = Out_Valid_g & ordy;
        dout = Data_Out_g;
        @(posedge CLOCK);
        #2;
        if (ao) delivered.push_back(dout);
    endtask

    logic acc;
    int   k;

    initial begin
        RESET_N = 1'b1;
        #1 RESET_N = 1'b0;
        #1;
        check("rst0_valid", 64'(Out_Valid_g), 64'd0);
        check("rst0_ready", 64'(In_Ready_g),  64'd1);
        check("rst0_ctrl",  64'(Ctrl_Out_g),  64'(CR));
        check("rst0_data",  64'(Data_Out_g),  64'd0);
        check("rst0_occ",   64'(Occupancy_g), 64'd0);
        @(posedge CLOCK);
        #2 RESET_N = 1'b1;

        // Streaming at full rate: entry i visible right after the edge that took it.
        delivered.delete();
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 16'(16'hC000 | i), 32'(i), 1'b1, 1'b0, acc);
            check("stream_acc",   64'(acc),         64'd1);
            check("stream_data",  64'(Data_Out_g),  64'(i));
            check("stream_occ",   64'(Occupancy_g), 64'd1);
        end
        cyc(1'b0, '0, '0, 1'b1, 1'b0, acc);
        check("drain_valid",  64'(Out_Valid_g), 64'd0);
        check("drain_ctrl_g", 64'(Ctrl_Out_g),  64'(16'hA5A5));
        check("drain_ctrl_u", 64'(Ctrl_Out_u),  64'(16'hC008));
        check("drain_data",   64'(Data_Out_g),  64'd8);
        check("stream_count", 64'(delivered.size()), 64'd8);
        for (int i = 0; i < 8; i++)
            check("stream_order", (i < delivered.size()) ? 64'(delivered[i]) : 64'hDEAD, 64'(i + 1));

        // Back-pressure: 1 sits in M, 2 lands in S, 3 waits upstream.
        delivered.delete();
        cyc(1'b1, 16'd1, 32'd1, 1'b0, 1'b0, acc);
        cyc(1'b1, 16'd2, 32'd2, 1'b0, 1'b0, acc);
        check("bp_occ",    64'(Occupancy_g), 64'd2);
        check("bp_ready",  64'(In_Ready_g),  64'd0);
        check("bp_data",   64'(Data_Out_g),  64'd1);
        check("mdl_size",  64'(q.size()),    64'd2);
        check("mdl_front", 64'(q[0].d),      64'd1);
        check("mdl_back",  64'(q[1].d),      64'd2);
        cyc(1'b1, 16'd3, 32'd3, 1'b0, 1'b0, acc);
        check("bp_hold_acc", 64'(acc), 64'd0);
        cyc(1'b1, 16'd3, 32'd3, 1'b0, 1'b0, acc);
        check("bp_hold_acc", 64'(acc), 64'd0);
        k = 3;
        for (int t = 0; t < 20 && (k <= 4 || Occupancy_g != 2'd0); t++) begin
            cyc(k <= 4, 16'(k), 32'(k), 1'b1, 1'b0, acc);
            if (acc) k++;
        end
        check("bp_count", 64'(delivered.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            check("bp_order", (i < delivered.size()) ? 64'(delivered[i]) : 64'hDEAD, 64'(i + 1));

        // Flush with both slots full and an input offered at the same edge.
        delivered.delete();
        cyc(1'b1, 16'h0A0A, 32'd10, 1'b0, 1'b0, acc);
        cyc(1'b1, 16'h0B0B, 32'd11, 1'b0, 1'b0, acc);
        check("fl_pre_occ", 64'(Occupancy_g), 64'd2);
        cyc(1'b1, 16'h0C0C, 32'd12, 1'b0, 1'b1, acc);
        check("fl_valid",  64'(Out_Valid_g), 64'd0);
        check("fl_occ",    64'(Occupancy_g), 64'd0);
        check("fl_ready",  64'(In_Ready_g),  64'd1);
        check("fl_ctrl_g", 64'(Ctrl_Out_g),  64'(16'hA5A5));
        check("fl_ctrl_u", 64'(Ctrl_Out_u),  64'(16'hA5A5));
        check("fl_data",   64'(Data_Out_g),  64'd10);
        for (int t = 0; t < 3; t++) cyc(1'b0, '0, '0, 1'b1, 1'b0, acc);
        check("fl_nothing_out", 64'(delivered.size()), 64'd0);

        // Asynchronous reset with both slots full, observed before any edge.
        cyc(1'b1, 16'h1111, 32'd20, 1'b0, 1'b0, acc);
        cyc(1'b1, 16'h2222, 32'd21, 1'b0, 1'b0, acc);
        check("rst_pre_occ", 64'(Occupancy_g), 64'd2);
        RESET_N = 1'b0;
        #1;
        check("rst_valid",  64'(Out_Valid_g), 64'd0);
        check("rst_ready",  64'(In_Ready_g),  64'd1);
        check("rst_ctrl_g", 64'(Ctrl_Out_g),  64'(16'hA5A5));
        check("rst_ctrl_u", 64'(Ctrl_Out_u),  64'(16'hA5A5));
        check("rst_data",   64'(Data_Out_g),  64'd0);
        check("rst_occ",    64'(Occupancy_g), 64'd0);
        @(posedge CLOCK);
        #2 RESET_N = 1'b1;
        cyc(1'b1, 16'h3333, 32'd30, 1'b1, 1'b0, acc);
        check("post_rst_acc",  64'(acc),         64'd1);
        check("post_rst_data", 64'(Data_Out_g),  64'd30);

        // Randomized traffic, with rare flushes and resets.
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                RESET_N = 1'b0;
                @(posedge CLOCK);
                #2 RESET_N = 1'b1;
            end else begin
                cyc($urandom_range(0, 9) < 7, 16'($urandom), 32'($urandom),
                    $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3, acc);
            end
            if (delivered.size() > 64) delivered.delete();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline stage register that replaces the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. Carries a control bundle and a data bundle between stages under a valid/ready handshake, with a two-entry skid buffer for full throughput under back-pressure. Flush squashes in-flight entries to a control bubble without touching data. Sits between any two adjacent pipeline stages; hazard logic drives `Flush` and observes `Out_Ready`/`In_Ready`.

## Interface
- `CTRL_W`, default 16: control bundle width (enables, selects, ALU ctrl); must be ≥1.
- `DATA_W`, default 128: data bundle width (operands, addresses, immediate, PC); must be ≥1.
- `CTRL_RESET`, default 0: control value loaded on reset and flush, and shown on `Ctrl_Out` for bubbles.
- `GATE_CTRL`, default 1: when 1, `Ctrl_Out` = `CTRL_RESET` whenever `Out_Valid`=0; when 0, `Ctrl_Out` shows raw main-entry control.

Ports:
- `CLOCK` in 1: single clock; all state on rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `In_Valid` in 1: upstream entry present.
- `In_Ready` out 1: stage can accept; registered.
- `Ctrl_In` in `CTRL_W`: upstream control bundle.
- `Data_In` in `DATA_W`: upstream data bundle.
- `Out_Valid` out 1: main entry valid.
- `Out_Ready` in 1: downstream accepts.
- `Ctrl_Out` out `CTRL_W`: main-entry control (gated per `GATE_CTRL`).
- `Data_Out` out `DATA_W`: main-entry data.
- `Flush` in 1: squash all entries this edge.
- `Occupancy` out 2: valid entries held, 0–2.

## Operation
- Storage: main entry (M) and skid entry (S), each {valid, ctrl, data}. Outputs always driven from M.
- Input transfer: `In_Valid`&`In_Ready` at a rising edge. Output transfer: `Out_Valid`&`Out_Ready`.
- `In_Ready` = !S.valid (registered, no combinational path from `Out_Ready`).
- Per edge, with Flush=0:
  - M empty: input transfer loads M.
  - M full, output transfer, S empty: input transfer loads M, else M.valid←0.
  - M full, output transfer, S full: S moves to M, S.valid←0 (`In_Ready` was 0; no input accepted).
  - M full, no output transfer: input transfer loads S.
- Flush=1: M.valid←0, S.valid←0, M.ctrl←S.ctrl←`CTRL_RESET`; data fields hold; any concurrent input transfer is discarded; any concurrent output transfer is still considered consumed downstream (downstream sees the pre-edge values).
- `Occupancy` = M.valid + S.valid.
- Reset (async, RESET_N=0): M/S valid←0, ctrl←`CTRL_RESET`, data←0. Therefore `Out_Valid`=0, `In_Ready`=1, `Ctrl_Out`=`CTRL_RESET`, `Data_Out`=0, `Occupancy`=0 — all immediately on assertion, not at the next edge. Reset mid-transfer drops all entries.
- Order preserved: entries leave in acceptance order; none duplicated or dropped except by Flush/reset.

## Timing
- Latency: accepted input appears on outputs the cycle after the accepting edge (1 cycle).
- Throughput: 1 entry/cycle while `Out_Ready`=1.
- Back-pressure: first stalled cycle absorbs one more entry into S; `In_Ready` falls the edge after S fills; rises the edge after S drains.
- `In_Ready` and `Out_Valid` depend only on registers; `Ctrl_Out` depends combinationally only on M state.
- Flush takes effect at the edge it is sampled; next cycle `Out_Valid`=0, `In_Ready`=1.
- Reset release: first input transfer possible at the first rising edge after `RESET_N` goes high.

## Test plan
- Reset: assert RESET_N=0 between edges with M,S full -> outputs go to `Out_Valid`=0, `In_Ready`=1, `Ctrl_Out`=0, `Data_Out`=0, `Occupancy`=0 without a clock edge.
- Streaming: `Out_Ready`=1, inputs 1..8 on consecutive cycles -> outputs 1..8 on consecutive cycles, each 1 cycle late, `Occupancy` ≤1.
- Back-pressure: stream 1,2,3,4; hold `Out_Ready`=0 from cycle of entry 1 -> entry 2 lands in S, `Occupancy`=2, `In_Ready`=0, entry 3 held upstream; release -> 1,2,3,4 delivered in order, none lost.
- Flush with full buffer plus concurrent input: M,S full, `In_Valid`=1, `Flush`=1 -> next cycle `Out_Valid`=0, `Occupancy`=0, `Ctrl_Out`=`CTRL_RESET`, `Data_Out` unchanged; input not delivered later.
- GATE_CTRL=0 vs 1, `CTRL_RESET`=16'hA5A5 after draining -> gated instance shows 16'hA5A5 when `Out_Valid`=0; ungated shows last control value.
- Random valid/ready/flush for 10k cycles with scoreboard -> in-order delivery, no duplicates, only flushed entries missing, `Occupancy` matches model.
